// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Instruction fetch controller. Issues sequential fetch requests
//             to instruction memory under a two-entry credit budget, buffers
//             in-order responses in a 2-entry {inst, pc} FIFO toward decode,
//             and handles EX-stage redirects by flushing buffered work and
//             discarding responses to requests that were already in flight.
//
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             redirect_val/pc    - redirect request and target from EX
//             stall              - decode cannot accept this cycle
//             imem_req_*         - fetch request channel (val/rdy/addr)
//             imem_resp_*        - in-order response channel, no backpressure
//             inst_val/inst/pc   - instruction toward decode
//             kill_IF            - fetch-stage instruction killed this cycle
//
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        imem_req_rdy,
    input  logic        imem_resp_val,
    input  logic [31:0] imem_resp_data,
    output logic        imem_req_val,
    output logic [31:0] imem_req_addr,
    output logic        inst_val,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        kill_IF
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_drop;
    logic [1:0]  w_drop_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_last_pc;

    // Response FIFO: {inst, pc} toward decode
    logic [31:0] r_rf_inst [2];
    logic [31:0] r_rf_pc   [2];
    logic        r_rf_rd;
    logic        r_rf_wr;
    logic [1:0]  r_rf_cnt;

    // Outstanding-request FIFO: PCs of requests awaiting a response
    logic [31:0] r_of_pc [2];
    logic        r_of_rd;
    logic        r_of_wr;
    logic [1:0]  r_of_cnt;

    logic        w_inst_val;
    logic        w_deq;
    logic        w_resp;
    logic        w_capture;
    logic        w_req_val;
    logic        w_accept;
    logic [2:0]  w_used;
    logic [1:0]  w_unanswered;
    logic        w_unused;

    // Only word-aligned targets are fetched; the low bits are dropped.
    assign w_unused = ^redirect_pc[1:0];

    assign w_inst_val = !rst && (r_rf_cnt != 2'd0) && !redirect_val;
    assign w_deq      = w_inst_val && !stall;

    // A response is only meaningful while something is outstanding.
    assign w_resp     = !rst && imem_resp_val && (r_of_cnt != 2'd0);
    assign w_capture  = w_resp && (r_state == ST_RUN) && !redirect_val;

    // Credits: buffered + outstanding, with this cycle's dequeue already freed.
    // A response only moves an entry between the two FIFOs, so it is neutral.
    assign w_used     = {1'b0, r_rf_cnt} + {1'b0, r_of_cnt} - {2'b00, w_deq};
    assign w_req_val  = !rst && (r_state == ST_RUN) && !redirect_val && (w_used < 3'd2);
    assign w_accept   = w_req_val && imem_req_rdy;

    // Requests still in flight after this cycle's response (if any) is consumed.
    assign w_unanswered = r_of_cnt - {1'b0, w_resp};

    assign imem_req_val  = w_req_val;
    assign imem_req_addr = r_fetch_pc;
    assign inst_val      = w_inst_val;
    assign inst          = w_inst_val ? r_rf_inst[r_rf_rd] : NOP_INST;
    assign inst_pc       = rst ? 32'h0 : (w_inst_val ? r_rf_pc[r_rf_rd] : r_last_pc);
    assign kill_IF       = !rst && redirect_val;

    // Next-state logic. The drop count always equals the number of in-flight
    // requests belonging to a flushed path, so a redirect during FLUSH simply
    // recomputes the same count.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        if (redirect_val) begin
            w_drop_nxt  = w_unanswered;
            w_state_nxt = (w_unanswered != 2'd0) ? ST_FLUSH : ST_RUN;
        end else if ((r_state == ST_FLUSH) && w_resp) begin
            w_drop_nxt  = r_drop - 2'd1;
            w_state_nxt = (r_drop == 2'd1) ? ST_RUN : ST_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_drop     <= 2'd0;
            r_fetch_pc <= RESET_PC;
            r_last_pc  <= 32'h0;
            r_rf_rd    <= 1'b0;
            r_rf_wr    <= 1'b0;
            r_rf_cnt   <= 2'd0;
            r_of_rd    <= 1'b0;
            r_of_wr    <= 1'b0;
            r_of_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;

            if (redirect_val) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_inst_val) begin
                r_last_pc <= r_rf_pc[r_rf_rd];
            end

            // Outstanding FIFO: pops on every response regardless of state,
            // since dropped responses still retire their request.
            if (w_accept) begin
                r_of_pc[r_of_wr] <= r_fetch_pc;
                r_of_wr          <= ~r_of_wr;
            end
            if (w_resp) begin
                r_of_rd <= ~r_of_rd;
            end
            r_of_cnt <= r_of_cnt + {1'b0, w_accept} - {1'b0, w_resp};

            if (redirect_val) begin
                r_rf_rd  <= r_rf_wr;
                r_rf_cnt <= 2'd0;
            end else begin
                if (w_capture) begin
                    r_rf_inst[r_rf_wr] <= imem_resp_data;
                    r_rf_pc[r_rf_wr]   <= r_of_pc[r_of_rd];
                    r_rf_wr            <= ~r_rf_wr;
                end
                if (w_deq) begin
                    r_rf_rd <= ~r_rf_rd;
                end
                r_rf_cnt <= r_rf_cnt + {1'b0, w_capture} - {1'b0, w_deq};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction presented whenever inst_val is low.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 redirect_val  input  1  EX-stage branch/mispredict redirect request.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 stall  input  1  decode/EX cannot accept an instruction this cycle.
REQ-008 imem_req_rdy  input  1  instruction memory accepts a request this cycle.
REQ-009 imem_resp_val  input  1  instruction memory response valid; no backpressure.
REQ-010 imem_resp_data  input  32  response instruction word.
REQ-011 imem_req_val  output  1  fetch request valid.
REQ-012 imem_req_addr  output  32  fetch request address.
REQ-013 inst_val  output  1  inst/inst_pc valid toward decode.
REQ-014 inst  output  32  instruction toward decode.
REQ-015 inst_pc  output  32  PC of inst.
REQ-016 kill_IF  output  1  combinational pulse marking the current fetch-stage instruction as killed.

Function
REQ-017 State SHALL be fetch_pc (32b), a 2-entry response FIFO of {inst, pc}, an outstanding-request FIFO of request PCs (depth 2), and FSM {RUN, FLUSH}.
REQ-018 Credit rule: imem_req_val SHALL be 1 only when state==RUN, redirect_val==0, and (fifo_count + outstanding) < 2, with dequeues in the same cycle counted as freed.
REQ-019 imem_req_addr SHALL equal fetch_pc; a request is accepted when imem_req_val && imem_req_rdy, and then fetch_pc increments by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0) and the request PC is pushed to the outstanding FIFO.
REQ-020 Responses return in order, at the earliest one cycle after acceptance; each imem_resp_val in RUN SHALL pop the oldest outstanding PC and push {imem_resp_data, that PC} into the response FIFO, visible at inst_val the next cycle.
REQ-021 inst_val SHALL equal (fifo_count != 0) && !redirect_val; inst/inst_pc SHALL show the FIFO head, or NOP_INST/last head PC when inst_val is 0.
REQ-022 The FIFO head SHALL dequeue when inst_val && !stall; stall SHALL NOT block issue while credits remain.
REQ-023 On redirect_val: the response FIFO is flushed, fetch_pc <= {redirect_pc[31:2], 2'b00}, kill_IF=1 that cycle, and no request is issued that cycle.
REQ-024 On redirect: for every outstanding request not answered in the redirect cycle, state SHALL go to FLUSH and hold a drop count equal to that number; a response arriving in the redirect cycle is dropped and is not counted.
REQ-025 In FLUSH: each imem_resp_val SHALL decrement the drop count and pop the outstanding FIFO without writing the response FIFO; at drop count 0 the FSM returns to RUN.
REQ-026 A new redirect during FLUSH SHALL update fetch_pc and keep the drop count; the last redirect wins.
REQ-027 Simultaneous request acceptance and response in RUN SHALL update both FIFOs with occupancy staying consistent; the total of entries plus outstanding never exceeds 2.
REQ-028 Priority SHALL be rst > redirect_val > response capture > dequeue/issue.

Reset
REQ-029 While rst=1 at a clock edge: fetch_pc<=RESET_PC, both FIFOs empty, drop count 0, FSM RUN.
REQ-030 While rst=1 the outputs SHALL be imem_req_val=0, inst_val=0, inst=NOP_INST, inst_pc=0, kill_IF=0.
REQ-031 Reset SHALL override a redirect or an outstanding response; responses to pre-reset requests arriving after reset are the memory's responsibility and shall not occur.
REQ-032 imem_req_val SHALL rise in the first cycle after rst deasserts, with imem_req_addr=RESET_PC.

Verification
REQ-033 Reset release with rdy=1 and 1-cycle response latency -> requests issued at 0x0 then 0x4, then 0x8; inst_val high from cycle 2 with inst_pc 0x0, 0x4, ... one per cycle.
REQ-034 stall=1 held for 5 cycles -> at most 2 requests issued, inst_val held with inst_pc constant, no response lost; release -> in-order delivery resumes.
REQ-035 redirect_val with redirect_pc=0x103 while 2 requests outstanding -> kill_IF=1, FSM FLUSH, next 2 responses dropped, next request addr 0x100.
REQ-036 Redirect in the same cycle as a response -> that response is dropped, inst_val=0 that cycle, next delivered inst_pc = redirect target.
REQ-037 fetch_pc=0xFFFF_FFFC accepted -> next imem_req_addr=0x0000_0000.
REQ-038 rst asserted mid-FLUSH -> next cycle FSM RUN, FIFOs empty, imem_req_addr=RESET_PC.
